alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised successor to the 16-bit combinational logic/arithmetic units.
- Generic WIDTH datapath covering the existing logic and arithmetic operations, plus operand swap/zero pre-processing.
- Adds status flags, a condition evaluator and an iterative shift-add multiplier.
- Valid/ready handshake on input and output, with a registered result stage; sits between register file and writeback/jump logic.

Parameters:
WIDTH, 16, datapath width in bits (>=2)
CNT_W, $clog2(WIDTH), multiply step counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept request this cycle
mode  in  2  0 logic, 1 arithmetic, 2 multiply, 3 reserved
op1  in  1  operation select high bit
op0  in  1  operation select low bit
zx  in  1  zero X operand (applied after swap)
sw  in  1  swap X and Y before use
cond  in  3  jump mask {lt,eq,gt}
x  in  WIDTH  operand X
y  in  WIDTH  operand Y
out_valid  out  1  result register holds a result
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  registered result
flag_zero  out  1  result == 0
flag_neg  out  1  result MSB
flag_carry  out  1  carry/borrow/overflow (see below)
jump  out  1  condition outcome for result
err  out  1  reserved mode was issued

Behaviour:
- Reset (clk edge with rst=1): state IDLE; out_valid, result, all flags, jump, err = 0. Reset mid-multiply aborts the operation with no output. rst has priority over all inputs.
- Operand prep: a = sw ? y : x; b = sw ? x : y; if zx then a = 0.
- Logic mode {op1,op0}: 00 a&b, 01 a|b, 10 a^b, 11 ~a. Carry = 0.
- Arithmetic mode: 00 a+b, 01 a+1, 10 a-b, 11 a-1; modulo 2^WIDTH.
  - Carry on add is the carry-out.
  - Carry on subtract is the borrow (1 when a < subtrahend, unsigned).
- Multiply mode (unsigned), op0 selects the half of the 2*WIDTH product:
  - op0=0: low WIDTH bits; carry = 1 if the high half is nonzero.
  - op0=1: high WIDTH bits; carry = 0.
  - op1 is ignored.
- Reserved mode: result 0, flags from a zero result, err = 1. err is held with the result and cleared on the next load.
- jump = (cond[2] & flag_neg) | (cond[1] & flag_zero) | (cond[0] & ~flag_neg & ~flag_zero), computed from the values loaded into the result register and registered with them.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Acceptance = in_valid & in_ready.
- FSM:
  - IDLE: on accepting logic, arithmetic or reserved mode, load result/flags/jump/err at the same edge; out_valid=1 next cycle (latency 1). On accepting multiply, latch operands and half-select, clear the accumulator, go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles; in_ready=0. On the final step, load the result register, set out_valid and return to IDLE. out_valid rises exactly WIDTH cycles after the accepting edge.
- Output hold: while out_valid & ~out_ready, result/flags/jump/err are stable and no new request is accepted.
- Drain with simultaneous accept (IDLE, out_valid & out_ready & in_valid): a single-cycle op reloads the result and out_valid stays 1. A multiply op sets out_valid=0 and enters MUL.
- out_valid & out_ready with no new load: out_valid=0 next cycle; result holds its last value.
- Input values outside the accepting cycle are don't-care.

Test Plan:
1. WIDTH=16, reset, then mode=0 op=00 x=0x00F0 y=0x0F0F -> 1 cycle later out_valid=1, result=0x0000, zero=1, carry=0; with cond=010, jump=1.
2. mode=1 op=10 x=5 y=7 cond=100 -> result=0xFFFE, neg=1, carry=1, jump=1. Then sw=1 zx=1 x=3 y=9 op=10 -> result=0xFFFD. Then op=00 x=0xFFFF y=1 -> result=0, zero=1, carry=1.
3. mode=2 op0=0 x=300 y=300 -> in_ready low for 16 cycles; out_valid exactly 16 cycles after accept; result=0x5F90, carry=1. Repeat with op0=1 -> result=0x0001, carry=0.
4. Backpressure: out_ready=0 with result pending, in_valid held -> in_ready=0, result stable. Raise out_ready with a new add (2+2) -> same edge drains and loads 0x0004; out_valid stays 1.
5. rst=1 at the 8th MUL cycle -> next cycle out_valid=0, all outputs 0, in_ready=1. A following mode=3 request -> err=1, result=0, zero=1.
6. Random back-to-back stream of all modes against a behavioural model with random out_ready, at WIDTH=16 and WIDTH=8 -> every result and flag matches, in order, with no drops or duplicates.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: valid/ready request channel with operands,
// and valid/ready result channel carrying result, status flags, jump and err.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic             op1;
  logic             op0;
  logic             zx;
  logic             sw;
  logic [2:0]       cond;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_carry;
  logic             jump;
  logic             err;

  modport master (
    output in_valid, mode, op1, op0, zx, sw, cond, x, y, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, jump, err
  );

  modport slave (
    input  in_valid, mode, op1, op0, zx, sw, cond, x, y, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, jump, err
  );
endinterface

// File: rtl/alu_pipe.sv
// WIDTH-bit logic/arithmetic unit with an iterative shift-add multiplier, status flags,
// jump evaluation and a registered valid/ready result stage.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_nxt;

  logic             in_ready, load_op, load_mul, start_mul;
  logic [WIDTH-1:0] a, b, op_res, mul_res, ld_res;
  logic             op_carry, op_err, mul_carry, ld_carry, ld_err;
  logic [2:0]       ld_cond;
  logic [WIDTH:0]   ext, step_sum;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               hi_sel;
  logic [2:0]         cond_q;

  logic             out_valid_q, zero_q, neg_q, carry_q, jump_q, err_q;
  logic [WIDTH-1:0] result_q;

  function automatic logic jump_of(input logic [2:0] c, input logic [WIDTH-1:0] r);
    return (c[2] & r[WIDTH-1]) | (c[1] & (r == '0)) | (c[0] & ~r[WIDTH-1] & (r != '0));
  endfunction

  // Single-cycle datapath: operand prep then logic/arithmetic select.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    a        = bus.sw ? bus.y : bus.x;
    b        = bus.sw ? bus.x : bus.y;
    ext      = '0;
    op_res   = '0;
    op_carry = 1'b0;
    op_err   = 1'b0;
    if (bus.zx) a = '0;
    case (bus.mode)
      2'd0: begin
        case ({bus.op1, bus.op0})
          2'b00:   op_res = a & b;
          2'b01:   op_res = a | b;
          2'b10:   op_res = a ^ b;
          default: op_res = ~a;
        endcase
      end
      2'd1: begin
        // Zero-extended subtraction leaves the borrow in the top bit.
        case ({bus.op1, bus.op0})
          2'b00:   ext = {1'b0, a} + {1'b0, b};
          2'b01:   ext = {1'b0, a} + (WIDTH+1)'(1);
          2'b10:   ext = {1'b0, a} - {1'b0, b};
          default: ext = {1'b0, a} - (WIDTH+1)'(1);
        endcase
        op_res   = ext[WIDTH-1:0];
        op_carry = ext[WIDTH];
      end
      2'd3:    op_err = 1'b1;
      default: op_res = '0;
    endcase
  end

  // One shift-add step: prod holds {partial sum, remaining multiplier bits}.
  always_comb begin
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    prod_nxt  = {step_sum, prod[WIDTH-1:1]};
    mul_res   = hi_sel ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
    mul_carry = ~hi_sel & (prod_nxt[2*WIDTH-1:WIDTH] != '0);
    ld_res    = load_mul ? mul_res   : op_res;
    ld_carry  = load_mul ? mul_carry : op_carry;
    ld_err    = load_mul ? 1'b0      : op_err;
    ld_cond   = load_mul ? cond_q    : bus.cond;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_op   = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~out_valid_q | bus.out_ready;
        if (bus.in_valid && in_ready) begin
          if (bus.mode == 2'd2) begin
            start_mul = 1'b1;
            state_nxt = MUL;
          end else begin
            load_op = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          load_mul  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: multiplier working registers carry no reset; they are always written by
  // start_mul before being read, and rst returns the FSM to IDLE which ignores them.
  always_ff @(posedge clk) begin
    if (start_mul) begin
      mcand  <= a;
      prod   <= {{WIDTH{1'b0}}, b};
      hi_sel <= bus.op0;
      cond_q <= bus.cond;
      cnt    <= '0;
    end else if (state == MUL) begin
      prod <= prod_nxt;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      jump_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (load_op || load_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_res;
      zero_q      <= (ld_res == '0);
      neg_q       <= ld_res[WIDTH-1];
      carry_q     <= ld_carry;
      jump_q      <= jump_of(ld_cond, ld_res);
      err_q       <= ld_err;
    end else if (start_mul || bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_neg   = neg_q;
  assign bus.flag_carry = carry_q;
  assign bus.jump       = jump_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=16 and WIDTH=8: directed steps plus a
// random stream, all results checked in order against a queued reference model.
module tb_alu_pipe;
  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        jump;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q16[$];
  exp_t q8[$];

  alu_pipe_if #(.WIDTH(16)) b16 ();
  alu_pipe_if #(.WIDTH(8))  b8 ();

  alu_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  alu_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [1:0] mode, input logic [1:0] op,
                                 input bit zx, input bit sw, input logic [2:0] cond,
                                 input logic [15:0] x, input logic [15:0] y);
    longint unsigned m, a, b, r, p;
    bit   c;
    exp_t e;
    m = (64'd1 << w) - 1;
    a = (sw ? 64'(y) : 64'(x)) & m;
    b = (sw ? 64'(x) : 64'(y)) & m;
    if (zx) a = 0;
    r = 0;
    c = 1'b0;
    e = '0;
    case (mode)
      2'd0: case (op)
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = ~a & m;
      endcase
      2'd1: case (op)
        2'd0:    begin r = (a + b) & m; c = ((a + b) >> w) != 0; end
        2'd1:    begin r = (a + 1) & m; c = ((a + 1) >> w) != 0; end
        2'd2:    begin r = (a - b) & m; c = (a < b); end
        default: begin r = (a - 1) & m; c = (a == 0); end
      endcase
      2'd2: begin
        p = a * b;
        if (op[0]) r = (p >> w) & m;
        else begin r = p & m; c = ((p >> w) != 0); end
      end
      default: e.err = 1'b1;
    endcase
    e.result = r[15:0];
    e.zero   = (r == 0);
    e.neg    = r[w-1];
    e.carry  = c;
    e.jump   = (cond[2] & e.neg) | (cond[1] & e.zero) | (cond[0] & ~e.neg & ~e.zero);
    return e;
  endfunction

  // Drives one request (starting at posedge+2) until accepted, pushing its expectation.
  task automatic issue(input bit sel, input logic [1:0] mode, input logic [1:0] op,
                       input bit zx, input bit sw, input logic [2:0] cond,
                       input logic [15:0] x, input logic [15:0] y, input bit rnd);
    int n = 0;
    bit acc = 1'b0;
    if (sel) begin
      b8.mode = mode; b8.op1 = op[1]; b8.op0 = op[0]; b8.zx = zx; b8.sw = sw;
      b8.cond = cond; b8.x = x[7:0]; b8.y = y[7:0]; b8.in_valid = 1'b1;
    end else begin
      b16.mode = mode; b16.op1 = op[1]; b16.op0 = op[0]; b16.zx = zx; b16.sw = sw;
      b16.cond = cond; b16.x = x; b16.y = y; b16.in_valid = 1'b1;
    end
    while (!acc && n < 300) begin
      if (rnd) begin
        if (sel) b8.out_ready = 1'($urandom_range(0, 1));
        else     b16.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (sel ? b8.in_ready : b16.in_ready) begin
        acc = 1'b1;
        if (sel) q8.push_back(model(8, mode, op, zx, sw, cond, x, y));
        else     q16.push_back(model(16, mode, op, zx, sw, cond, x, y));
      end
      @(posedge clk); #2;
      n++;
    end
    if (sel) b8.in_valid = 1'b0;
    else     b16.in_valid = 1'b0;
    check("accept_in_time", 32'(acc), 32'd1);
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    if (sel) b8.out_ready = 1'b1;
    else     b16.out_ready = 1'b1;
    while (((sel ? q8.size() : q16.size()) != 0) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check(sel ? "q8_drained" : "q16_drained", 32'(sel ? q8.size() : q16.size()), 32'd0);
  endtask

  // Scoreboards: each handshake on the result channel pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (b16.out_valid && b16.out_ready) begin
      check("m16_pending", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("m16_result", 32'(b16.result), 32'(e.result));
        check("m16_flags", 32'({b16.flag_zero, b16.flag_neg, b16.flag_carry, b16.jump, b16.err}),
              32'({e.zero, e.neg, e.carry, e.jump, e.err}));
      end
    end
    if (b8.out_valid && b8.out_ready) begin
      check("m8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("m8_result", 32'(b8.result), 32'(e.result));
        check("m8_flags", 32'({b8.flag_zero, b8.flag_neg, b8.flag_carry, b8.jump, b8.err}),
              32'({e.zero, e.neg, e.carry, e.jump, e.err}));
      end
    end
  end

  initial begin
    int n;
    bit busy_ok;
    rst = 1'b1;
    b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.mode = '0; b16.op1 = 1'b0; b16.op0 = 1'b0;
    b16.zx = 1'b0; b16.sw = 1'b0; b16.cond = '0; b16.x = '0; b16.y = '0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.mode = '0; b8.op1 = 1'b0; b8.op0 = 1'b0;
    b8.zx = 1'b0; b8.sw = 1'b0; b8.cond = '0; b8.x = '0; b8.y = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(b16.out_valid), 32'd0);
    check("rst_result", 32'(b16.result), 32'd0);
    check("rst_flags", 32'({b16.flag_zero, b16.flag_neg, b16.flag_carry, b16.jump, b16.err}), 32'd0);
    check("rst_in_ready", 32'(b16.in_ready), 32'd1);
    check("rst_in_ready8", 32'(b8.in_ready), 32'd1);

    // Logic AND giving zero, eq-jump
    issue(0, 2'd0, 2'b00, 0, 0, 3'b010, 16'h00F0, 16'h0F0F, 0);
    check("t1_valid", 32'(b16.out_valid), 32'd1);
    check("t1_result", 32'(b16.result), 32'h0000);
    check("t1_zc_jump", 32'({b16.flag_zero, b16.flag_carry, b16.jump}), 32'b101);

    // Subtract with borrow, swap+zero, add wrapping to zero
    issue(0, 2'd1, 2'b10, 0, 0, 3'b100, 16'd5, 16'd7, 0);
    check("t2_sub_result", 32'(b16.result), 32'hFFFE);
    check("t2_sub_nc_jump", 32'({b16.flag_neg, b16.flag_carry, b16.jump}), 32'b111);
    issue(0, 2'd1, 2'b10, 1, 1, 3'b000, 16'd3, 16'd9, 0);
    check("t2_swzx_result", 32'(b16.result), 32'hFFFD);
    issue(0, 2'd1, 2'b00, 0, 0, 3'b000, 16'hFFFF, 16'd1, 0);
    check("t2_add_result", 32'(b16.result), 32'h0000);
    check("t2_add_zc", 32'({b16.flag_zero, b16.flag_carry}), 32'b11);

    // Multiply latency and both halves
    for (int h = 0; h < 2; h++) begin
      issue(0, 2'd2, {1'b0, 1'(h)}, 0, 0, 3'b000, 16'd300, 16'd300, 0);
      n = 0;
      busy_ok = 1'b1;
      while (!b16.out_valid && n < 100) begin
        if (b16.in_ready) busy_ok = 1'b0;
        @(posedge clk); #2;
        n++;
      end
      check("t3_latency", 32'(n), 32'd16);
      check("t3_busy", 32'(busy_ok), 32'd1);
      check("t3_result", 32'(b16.result), (h == 0) ? 32'h5F90 : 32'h0001);
      check("t3_carry", 32'(b16.flag_carry), (h == 0) ? 32'd1 : 32'd0);
    end

    // Backpressure: hold a result, then drain and load in the same edge
    @(posedge clk); #2;
    b16.out_ready = 1'b0;
    issue(0, 2'd0, 2'b01, 0, 0, 3'b000, 16'h1200, 16'h0034, 0);
    b16.mode = 2'd1; b16.op1 = 1'b0; b16.op0 = 1'b0; b16.zx = 1'b0; b16.sw = 1'b0;
    b16.cond = 3'b001; b16.x = 16'd2; b16.y = 16'd2; b16.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("t4_stall_ready", 32'(b16.in_ready), 32'd0);
      check("t4_stall_result", 32'(b16.result), 32'h1234);
    end
    b16.out_ready = 1'b1;
    q16.push_back(model(16, 2'd1, 2'b00, 0, 0, 3'b001, 16'd2, 16'd2));
    @(posedge clk); #2;
    b16.in_valid = 1'b0;
    check("t4_valid_kept", 32'(b16.out_valid), 32'd1);
    check("t4_result", 32'(b16.result), 32'h0004);

    // Reset in the 8th multiply cycle aborts without output
    issue(0, 2'd2, 2'b00, 0, 0, 3'b000, 16'd1234, 16'd77, 0);
    void'(q16.pop_back());
    repeat (7) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("t5_valid", 32'(b16.out_valid), 32'd0);
    check("t5_outputs", 32'({b16.result, b16.flag_zero, b16.flag_neg, b16.flag_carry, b16.jump, b16.err}), 32'd0);
    check("t5_in_ready", 32'(b16.in_ready), 32'd1);
    issue(0, 2'd3, 2'b00, 0, 0, 3'b000, 16'h5555, 16'hAAAA, 0);
    check("t5_err", 32'({b16.err, b16.flag_zero}), 32'b11);
    check("t5_result", 32'(b16.result), 32'd0);
    repeat (20) begin @(posedge clk); #2; end
    check("t5_no_ghost", 32'(b16.out_valid), 32'd0);

    // Random back-to-back streams at both widths
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 60; i++) begin
        logic [15:0] rx, ry;
        rx = 16'($urandom);
        ry = 16'($urandom);
        if ($urandom_range(0, 4) == 0) rx = 16'hFFFF;
        if ($urandom_range(0, 4) == 0) ry = 16'h0000;
        issue(1'(s), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), rx, ry, 1);
      end
      drain(1'(s));
    end

    check("q16_empty", 32'(q16.size()), 32'd0);
    check("q8_empty", 32'(q8.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
